// File: rtl/ro_puf_pkg.sv
// Shared types and constants for the RO-PUF response generator.
// Holds the FSM state enum, LFSR taps, default parameters and LFSR step.
package ro_puf_pkg;

   typedef enum logic [2:0] {
      IDLE,
      SETTLE,
      MEASURE,
      CAPTURE,
      DONE
   } state_t;

   // Feedback taps at bits 7,5,4,3
   localparam logic [7:0] LFSR_TAPS = 8'hB8;

   localparam int DEF_SEL_W          = 4;
   localparam int DEF_SETTLE_CYCLES  = 4;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

   function automatic logic [7:0] lfsr_next(input logic [7:0] l);
      return {l[6:0], ^(l & LFSR_TAPS)};
   endfunction

endpackage

// File: rtl/ro_puf_lfsr8.sv
// 8-bit Fibonacci LFSR that generates RO pair selects.
// Ports: clk, rst_n, load+seed (zero seed maps to 1), advance, state.
module ro_puf_lfsr8
   import ro_puf_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] seed,
   input  logic       advance,
   output logic [7:0] state
);

   logic [7:0] lfsr_q;

   // The all-zero state would lock the LFSR, so it is never loaded
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lfsr_q <= 8'h01;
      end else if (load) begin
         lfsr_q <= (seed == 8'h00) ? 8'h01 : seed;
      end else if (advance) begin
         lfsr_q <= lfsr_next(lfsr_q);
      end
   end

   assign state = lfsr_q;

endmodule

// File: rtl/ro_puf_response_gen.sv
// Sequences RO-pair measurements on an external edge counter and packs
// count comparisons into an N_BITS response word on a valid/ready port.
module ro_puf_response_gen
   import ro_puf_pkg::*;
#(
   parameter int N_BITS         = 16,
   parameter int SEL_W          = DEF_SEL_W,
   parameter int SETTLE_CYCLES  = DEF_SETTLE_CYCLES,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic [7:0]        challenge,
   output logic              busy,
   output logic [SEL_W-1:0]  sel_a,
   output logic [SEL_W-1:0]  sel_b,
   output logic              ctr_start,
   input  logic              ctr_done,
   input  logic [7:0]        count1,
   input  logic [7:0]        count2,
   output logic [N_BITS-1:0] resp,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_err,
   output logic [7:0]        tie_count
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + SETTLE_CYCLES + 1);
   localparam int IW = $clog2(N_BITS);

   localparam logic [TW-1:0] SET_LAST = TW'(SETTLE_CYCLES - 1);
   localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(N_BITS - 1);

   state_t state_q, state_d;

   logic [TW-1:0]     timer_q;
   logic [IW-1:0]     idx_q;
   logic [N_BITS-1:0] resp_q;
   logic [7:0]        tie_q;
   logic              err_q;
   logic [7:0]        lfsr;
   logic              accept;
   logic              cmp_bit;
   logic              is_tie;

   assign accept  = (state_q == IDLE) && req;
   assign cmp_bit = count1 > count2;
   assign is_tie  = count1 == count2;

   ro_puf_lfsr8 u_lfsr (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (accept),
      .seed    (challenge),
      .advance (state_q == CAPTURE),
      .state   (lfsr)
   );

   // Both mux inputs on the same RO would compare it with itself
   always_comb begin
      sel_a = lfsr[SEL_W-1:0];
      sel_b = lfsr[2*SEL_W-1:SEL_W];
      if (sel_b == sel_a) begin
         sel_b = lfsr[SEL_W-1:0] ^ SEL_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE: begin
            if (req) state_d = SETTLE;
         end
         SETTLE: begin
            if (timer_q == SET_LAST) state_d = MEASURE;
         end
         MEASURE: begin
            if (ctr_done) begin
               state_d = CAPTURE;
            end else if (timer_q == TO_LAST) begin
               state_d = DONE;
            end
         end
         CAPTURE: begin
            state_d = (idx_q == IDX_LAST) ? DONE : SETTLE;
         end
         DONE: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         timer_q <= '0;
         idx_q   <= '0;
         resp_q  <= '0;
         tie_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               timer_q <= '0;
               if (req) begin
                  idx_q  <= '0;
                  resp_q <= '0;
                  tie_q  <= '0;
                  err_q  <= 1'b0;
               end
            end
            SETTLE: begin
               timer_q <= (timer_q == SET_LAST) ? '0 : timer_q + TW'(1);
            end
            MEASURE: begin
               if (ctr_done) begin
                  timer_q <= '0;
               end else if (timer_q == TO_LAST) begin
                  timer_q <= '0;
                  err_q   <= 1'b1;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end
            CAPTURE: begin
               resp_q[idx_q] <= cmp_bit;
               if (is_tie && tie_q != 8'hFF) begin
                  tie_q <= tie_q + 8'd1;
               end
               if (idx_q != IDX_LAST) begin
                  idx_q <= idx_q + IW'(1);
               end
            end
            DONE: begin
               timer_q <= '0;
            end
            default: timer_q <= '0;
         endcase
      end
   end

   // Counter stays enabled through CAPTURE so the counts remain frozen
   assign ctr_start  = (state_q == MEASURE) || (state_q == CAPTURE);
   assign busy       = state_q != IDLE;
   assign resp_valid = state_q == DONE;
   assign resp       = resp_q;
   assign resp_err   = err_q;
   assign tie_count  = tie_q;

endmodule

// File: tb/tb_ro_puf_response_gen.sv
// Bench for ro_puf_response_gen with a behavioural RO edge-counter model.
// Vector table plus scoreboard of predicted responses and latencies.
module tb_ro_puf_response_gen;

   localparam int NB  = 4;
   localparam int SET = 4;
   localparam int TO  = 64;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req;
   logic [7:0]    challenge;
   logic          busy;
   logic [3:0]    sel_a;
   logic [3:0]    sel_b;
   logic          ctr_start;
   logic          ctr_done;
   logic [7:0]    count1;
   logic [7:0]    count2;
   logic [NB-1:0] resp;
   logic          resp_valid;
   logic          resp_ready;
   logic          resp_err;
   logic [7:0]    tie_count;

   int checks = 0;
   int errors = 0;
   int mode   = 0;

   always #5 clk = ~clk;

   ro_puf_response_gen #(
      .N_BITS         (NB),
      .SETTLE_CYCLES  (SET),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .challenge  (challenge),
      .busy       (busy),
      .sel_a      (sel_a),
      .sel_b      (sel_b),
      .ctr_start  (ctr_start),
      .ctr_done   (ctr_done),
      .count1     (count1),
      .count2     (count2),
      .resp       (resp),
      .resp_valid (resp_valid),
      .resp_ready (resp_ready),
      .resp_err   (resp_err),
      .tie_count  (tie_count)
   );

   // ---------------- counter model ----------------
   // mode 0: c1>c2 always; 1: even lt / odd tie; 2: as 0, bit 2 never done
   // mode 3: counts from selects + stale done while start low
   // mode 4: only bit 0 has c1>c2
   function automatic logic [15:0] counts_of(input int md, input int i,
                                             input logic [3:0] a,
                                             input logic [3:0] b);
      case (md)
         1:       return (i % 2 == 0) ? {8'd100, 8'd150} : {8'd120, 8'd120};
         3:       return {a, 4'h0, b, 4'h0};
         4:       return (i == 0) ? {8'd248, 8'd200} : {8'd100, 8'd150};
         default: return {8'd248, 8'd200};
      endcase
   endfunction

   function automatic int dly_of(input int i);
      return 1 + (i % 3);
   endfunction

   logic [7:0] hi_cnt = '0;
   logic       prev_start = 1'b0;
   int         meas_n = 0;

   always @(posedge clk) begin
      if (!busy) meas_n <= 0;
      else if (prev_start && !ctr_start) meas_n <= meas_n + 1;
      prev_start <= ctr_start;
      hi_cnt <= ctr_start ? hi_cnt + 8'd1 : 8'd0;
   end

   always_comb begin
      ctr_done = 1'b0;
      if (ctr_start) begin
         ctr_done = (int'(hi_cnt) >= dly_of(meas_n)) &&
                    !(mode == 2 && meas_n == 2);
      end else if (mode == 3) begin
         ctr_done = 1'b1;
      end
      {count1, count2} = counts_of(mode, meas_n, sel_a, sel_b);
   end

   // ---------------- prediction ----------------
   typedef struct {
      logic [NB-1:0] resp;
      logic          err;
      logic [7:0]    tie;
      int            lat;
   } exp_t;

   exp_t sb[$];

   function automatic exp_t predict(input logic [7:0] seed, input int md);
      exp_t e;
      logic [7:0] l;
      logic [3:0] a, b;
      logic [15:0] c;
      e.resp = '0;
      e.err  = 1'b0;
      e.tie  = 8'd0;
      e.lat  = 1;
      l = (seed == 8'h00) ? 8'h01 : seed;
      for (int i = 0; i < NB; i++) begin
         a = l[3:0];
         b = l[7:4];
         if (a == b) b = a ^ 4'h1;
         if (md == 2 && i == 2) begin
            e.err = 1'b1;
            e.lat += SET + TO;
            break;
         end
         c = counts_of(md, i, a, b);
         e.resp[i] = c[15:8] > c[7:0];
         if (c[15:8] == c[7:0]) e.tie++;
         e.lat += SET + (dly_of(i) + 1) + 1;
         l = {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
      end
      return e;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic run_case(input logic [7:0] seed, input int md,
                           input logic [3:0] sa, input logic [3:0] sb_exp,
                           input int hold);
      exp_t e;
      int lat;
      logic [NB-1:0] r0;
      mode = md;
      challenge = seed;
      sb.push_back(predict(seed, md));
      req = 1'b1;
      @(posedge clk); #1;
      req = 1'b0;
      lat = 1;
      chk("busy_after_req", busy, 1);
      chk("sel_a_first", sel_a, sa);
      chk("sel_b_first", sel_b, sb_exp);
      while (!resp_valid && lat < 2000) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) begin
         checks++;
         errors++;
         $display("FAIL resp_valid_wait: no response after %0d cycles", lat);
         sb.delete();
         rst_n = 1'b0; #2; rst_n = 1'b1;
         return;
      end
      if (sb.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL scoreboard: response with empty queue");
         return;
      end
      e = sb.pop_front();
      chk("resp", resp, e.resp);
      chk("resp_err", resp_err, e.err);
      chk("tie_count", tie_count, e.tie);
      chk("latency", lat, e.lat);
      chk("ctr_start_done", ctr_start, 0);
      r0 = resp;
      for (int c = 0; c < hold; c++) begin
         if (c == 3) req = 1'b1;
         @(posedge clk); #1;
         req = 1'b0;
         chk("hold_valid", resp_valid, 1);
         chk("hold_busy", busy, 1);
         chk("hold_resp", resp, r0);
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      chk("valid_after_ready", resp_valid, 0);
      chk("busy_after_ready", busy, 0);
      chk("resp_retained", resp, e.resp);
      if (hold > 0) begin
         repeat (3) begin
            @(posedge clk); #1;
            chk("no_queued_req", busy, 0);
         end
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [7:0] seed;
      int         md;
      logic [3:0] sa;
      logic [3:0] sb;
      int         hold;
   } vec_t;

   vec_t vecs[7];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vecs[0] = '{8'h5A, 0, 4'hA, 4'h5, 0};
      vecs[1] = '{8'h5A, 1, 4'hA, 4'h5, 0};
      vecs[2] = '{8'h00, 3, 4'h1, 4'h0, 0};
      vecs[3] = '{8'h33, 3, 4'h3, 4'h2, 0};
      vecs[4] = '{8'h5A, 2, 4'hA, 4'h5, 0};
      vecs[5] = '{8'hC7, 4, 4'h7, 4'hC, 0};
      vecs[6] = '{8'hFF, 3, 4'hF, 4'hE, 10};

      rst_n      = 1'b0;
      req        = 1'b0;
      challenge  = 8'h00;
      resp_ready = 1'b0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_ctr_start", ctr_start, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp", resp, 0);
      chk("rst_resp_err", resp_err, 0);
      chk("rst_tie_count", tie_count, 0);
      chk("rst_sel_a", sel_a, 1);
      chk("rst_sel_b", sel_b, 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[v]) begin
         run_case(vecs[v].seed, vecs[v].md, vecs[v].sa, vecs[v].sb,
                  vecs[v].hold);
      end

      // Reset during MEASURE of bit 1 aborts with no response
      begin
         int k;
         mode = 0;
         challenge = 8'h96;
         sb.push_back(predict(8'h96, 0));
         req = 1'b1;
         @(posedge clk); #1;
         req = 1'b0;
         k = 0;
         while (!(meas_n == 1 && ctr_start) && k < 200) begin
            @(posedge clk); #1;
            k++;
         end
         chk("reach_bit1_measure", (meas_n == 1 && ctr_start), 1);
         chk("resp_bit0_before_rst", resp[0], 1);
         #2 rst_n = 1'b0;
         #1;
         chk("arst_busy", busy, 0);
         chk("arst_ctr_start", ctr_start, 0);
         chk("arst_resp", resp, 0);
         chk("arst_resp_valid", resp_valid, 0);
         chk("arst_tie_count", tie_count, 0);
         sb.delete();
         @(posedge clk); #1;
         rst_n = 1'b1;
         @(posedge clk); #1;
         chk("post_rst_idle", busy, 0);
      end
      run_case(8'h3C, 3, 4'hC, 4'h3, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
